// File: rtl/approx_adder_pipe_eval_if.sv
// Operand/result stream bundle for the approximate adder evaluator; the source side
// drives operands and out_ready, the adder drives in_ready and results.
interface approx_adder_pipe_eval_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_exact;
  logic [WIDTH+1:0] out_err;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_exact, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_exact, out_err
  );
endinterface

// File: rtl/approx_adder_pipe_eval.sv
// Lower-part-OR approximate adder with exact reference and signed error; 2-cycle latency, 1 beat/cycle,
// stalls ripple back through in_ready with results held stable. APPROX_ERR_STATS_EN adds error statistics.
module approx_adder_pipe_eval #(
  parameter int WIDTH      = 4,
  parameter int APPROX_LSB = 2,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef APPROX_ERR_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] stat_samples,
  output logic [CNT_W-1:0] stat_err_cnt,
  output logic [WIDTH:0]   stat_max_abs,
  output logic [CNT_W-1:0] stat_sum_abs,
`endif
  approx_adder_pipe_eval_if.slave bus
);
  localparam int K = APPROX_LSB;

  logic s2_adv;
  logic s1_adv;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s2_sum_q, s2_sum_d;
  logic [WIDTH:0]   s2_exact_q, s2_exact_d;
  logic [WIDTH+1:0] s2_err_q, s2_err_d;

  logic [WIDTH:0]   approx_sum;
  logic [WIDTH:0]   exact_sum;
  logic [WIDTH:0]   sel_sum;
  logic             carry_k;

  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_sum   = s2_sum_q;
  assign bus.out_exact = s2_exact_q;
  assign bus.out_err   = s2_err_q;

  // Low part is a carry-free OR; only the top low-bit pair feeds a carry upward.
  generate
    if (K == 0) begin : g_no_lo
      assign carry_k = 1'b0;
    end else begin : g_lo
      assign approx_sum[K-1:0] = s1_a_q[K-1:0] | s1_b_q[K-1:0];
      assign carry_k           = s1_a_q[K-1] & s1_b_q[K-1];
    end

    if (K == WIDTH) begin : g_no_hi
      assign approx_sum[WIDTH] = carry_k;
    end else begin : g_hi
      assign approx_sum[WIDTH:K] = {1'b0, s1_a_q[WIDTH-1:K]} + {1'b0, s1_b_q[WIDTH-1:K]}
                                 + {{(WIDTH-K){1'b0}}, carry_k};
    end
  endgenerate

  assign exact_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign sel_sum   = s1_mode_q ? approx_sum : exact_sum;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d    = bus.in_a;
        s1_b_d    = bus.in_b;
        s1_mode_d = bus.in_mode;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_exact_d = s2_exact_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d   = sel_sum;
        s2_exact_d = exact_sum;
        s2_err_d   = {1'b0, sel_sum} - {1'b0, exact_sum};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_exact_q <= '0;
      s2_err_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_exact_q <= s2_exact_d;
      s2_err_q   <= s2_err_d;
    end
  end

`ifdef APPROX_ERR_STATS_EN
  localparam int SW = ((CNT_W > WIDTH + 1) ? CNT_W : WIDTH + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_xfer;
  logic [WIDTH:0]   abs_err;
  logic [SW-1:0]    sum_ext;
  logic [CNT_W-1:0] stat_samples_q, stat_samples_d;
  logic [CNT_W-1:0] stat_err_cnt_q, stat_err_cnt_d;
  logic [WIDTH:0]   stat_max_abs_q, stat_max_abs_d;
  logic [CNT_W-1:0] stat_sum_abs_q, stat_sum_abs_d;

  assign out_xfer = s2_valid_q && bus.out_ready;
  // |err| always fits in WIDTH+1 bits, so the negation can be done on the low bits only.
  assign abs_err  = s2_err_q[WIDTH+1] ? (~s2_err_q[WIDTH:0] + (WIDTH+1)'(1)) : s2_err_q[WIDTH:0];
  assign sum_ext  = SW'(stat_sum_abs_q) + SW'(abs_err);

  always_comb begin
    stat_samples_d = stat_samples_q;
    stat_err_cnt_d = stat_err_cnt_q;
    stat_max_abs_d = stat_max_abs_q;
    stat_sum_abs_d = stat_sum_abs_q;
    if (stats_clr) begin
      stat_samples_d = '0;
      stat_err_cnt_d = '0;
      stat_max_abs_d = '0;
      stat_sum_abs_d = '0;
    end else if (out_xfer) begin
      if (stat_samples_q != CNT_MAX) stat_samples_d = stat_samples_q + CNT_W'(1);
      if ((s2_err_q != '0) && (stat_err_cnt_q != CNT_MAX)) stat_err_cnt_d = stat_err_cnt_q + CNT_W'(1);
      if (abs_err > stat_max_abs_q) stat_max_abs_d = abs_err;
      stat_sum_abs_d = (sum_ext > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_samples_q <= '0;
      stat_err_cnt_q <= '0;
      stat_max_abs_q <= '0;
      stat_sum_abs_q <= '0;
    end else begin
      stat_samples_q <= stat_samples_d;
      stat_err_cnt_q <= stat_err_cnt_d;
      stat_max_abs_q <= stat_max_abs_d;
      stat_sum_abs_q <= stat_sum_abs_d;
    end
  end

  assign stat_samples = stat_samples_q;
  assign stat_err_cnt = stat_err_cnt_q;
  assign stat_max_abs = stat_max_abs_q;
  assign stat_sum_abs = stat_sum_abs_q;
`endif
endmodule
